// File: rtl/wdt_kick_ctrl.sv
// Kick validation, restart retiming and config lock for the watchdog counter.
// Optional macro WDT_WINDOW_EN enables the closed-window (early kick) check.
module wdt_kick_ctrl #(
  parameter int                 WDT_CNT_WIDTH = 32,
  parameter logic [7:0]         KICK_KEY      = 8'h76,
  parameter logic [31:0]        UNLOCK_KEY    = 32'h1ACCE551
) (
  input  logic                     i_pclk,
  input  logic                     i_preset,
  input  logic                     i_wdt_clk_en,
  input  logic                     i_wdt_en,
  input  logic                     i_wr_crr,
  input  logic                     i_wr_lock,
  input  logic                     i_clr_err,
  input  logic [31:0]              i_wdata,
  input  logic [WDT_CNT_WIDTH-1:0] i_cnt,
  input  logic [WDT_CNT_WIDTH-1:0] i_win_val,
  output logic                     o_restart,
  output logic                     o_cfg_wr_ok,
  output logic                     o_key_err,
  output logic                     o_early_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FIRE} state_t;

  state_t r_state, w_nxt;
  logic   r_restart, r_cfg_wr_ok, r_key_err;
  logic   w_kick, w_key_ok, w_win_open, w_accept, w_bad_key;

  assign w_kick    = i_wr_crr & i_wdt_en;
  assign w_key_ok  = (i_wdata[7:0] == KICK_KEY);
  assign w_bad_key = w_kick & ~w_key_ok;
  assign w_accept  = w_kick & w_key_ok & w_win_open;

`ifdef WDT_WINDOW_EN
  logic r_early_err, w_early;
  // Down-counter above the threshold means the window has not opened yet.
  assign w_win_open  = (i_cnt <= i_win_val);
  assign w_early     = w_kick & w_key_ok & ~w_win_open;
  assign o_early_err = r_early_err;

  always_ff @(posedge i_pclk) begin
    if (i_preset)     r_early_err <= 1'b0;
    else if (w_early) r_early_err <= 1'b1;
    else if (i_clr_err) r_early_err <= 1'b0;
  end
`else
  logic w_unused_win;
  assign w_unused_win = ^{i_cnt, i_win_val};
  assign w_win_open   = 1'b1;
  assign o_early_err  = 1'b0;
`endif

  // Kicks arriving in PEND/FIRE are merged into the level already in flight.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)     w_nxt = ST_PEND;
      ST_PEND: if (i_wdt_clk_en) w_nxt = ST_FIRE;
      ST_FIRE:                   w_nxt = ST_IDLE;
      default:                   w_nxt = ST_IDLE;
    endcase
    if (!i_wdt_en) w_nxt = ST_IDLE;
  end

  always_ff @(posedge i_pclk) begin
    if (i_preset) begin
      r_state     <= ST_IDLE;
      r_restart   <= 1'b0;
      r_cfg_wr_ok <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_restart <= (w_nxt == ST_PEND) || (w_nxt == ST_FIRE);
      if (i_wr_lock) r_cfg_wr_ok <= (i_wdata == UNLOCK_KEY);
      if (w_bad_key)      r_key_err <= 1'b1;
      else if (i_clr_err) r_key_err <= 1'b0;
    end
  end

  assign o_restart   = r_restart;
  assign o_cfg_wr_ok = r_cfg_wr_ok;
  assign o_key_err   = r_key_err;

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
// Directed bench for wdt_kick_ctrl; window scenarios build with WDT_WINDOW_EN.
module tb_wdt_kick_ctrl;
  logic        pclk = 1'b0;
  logic        preset, clk_en, wdt_en, wr_crr, wr_lock, clr_err;
  logic [31:0] wdata, cnt, win_val;
  logic        restart, cfg_wr_ok, key_err, early_err;
  int          total = 0;
  int          bad = 0;
  int          ticks_hi;

  always #5 pclk = ~pclk;

  wdt_kick_ctrl dut (
    .i_pclk(pclk), .i_preset(preset), .i_wdt_clk_en(clk_en), .i_wdt_en(wdt_en),
    .i_wr_crr(wr_crr), .i_wr_lock(wr_lock), .i_clr_err(clr_err), .i_wdata(wdata),
    .i_cnt(cnt), .i_win_val(win_val), .o_restart(restart), .o_cfg_wr_ok(cfg_wr_ok),
    .o_key_err(key_err), .o_early_err(early_err)
  );

  // Advance one edge; count ticks on which the counter would see restart high.
  task automatic step();
    if (clk_en && restart) ticks_hi++;
    @(posedge pclk); #1;
  endtask

  task automatic idle_inputs();
    clk_en = 0; wr_crr = 0; wr_lock = 0; clr_err = 0; wdata = 0;
  endtask

  task automatic do_reset();
    preset = 1; step(); step(); preset = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); wdt_en = 1; cnt = 0; win_val = '1;
    do_reset();
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL reset_restart got=%b exp=0", restart); end
    total++; if (cfg_wr_ok !== 1'b0) begin bad++; $display("FAIL reset_cfg got=%b exp=0", cfg_wr_ok); end
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL reset_key_err got=%b exp=0", key_err); end
    total++; if (early_err !== 1'b0) begin bad++; $display("FAIL reset_early_err got=%b exp=0", early_err); end
  endtask

  task automatic test_kick();
    ticks_hi = 0;
    wr_crr = 1; wdata = 32'h0000_0076; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL kick_rise got=%b exp=1", restart); end
    for (int i = 1; i < 12; i++) begin
      clk_en = (i % 4 == 3);
      step();
      // high through the tick at i=3 plus one more cycle (FIRE), then low
      total++;
      if (restart !== (i <= 3)) begin bad++; $display("FAIL kick_level i=%0d got=%b exp=%b", i, restart, (i <= 3)); end
    end
    clk_en = 0;
    total++; if (ticks_hi !== 1) begin bad++; $display("FAIL kick_ticks got=%0d exp=1", ticks_hi); end
  endtask

  task automatic test_bad_key();
    wr_crr = 1; wdata = 32'h0000_0075; step(); wr_crr = 0; wdata = 0;
    total++; if (key_err !== 1'b1) begin bad++; $display("FAIL badkey_set got=%b exp=1", key_err); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL badkey_restart got=%b exp=0", restart); end
    step();
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL badkey_restart2 got=%b exp=0", restart); end
    clr_err = 1; step(); clr_err = 0;
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL badkey_clr got=%b exp=0", key_err); end
    // set wins over a simultaneous clear; upper wdata bits do not rescue a bad key
    wr_crr = 1; clr_err = 1; wdata = 32'hFFFF_FF00; step(); wr_crr = 0; clr_err = 0; wdata = 0;
    total++; if (key_err !== 1'b1) begin bad++; $display("FAIL badkey_setwins got=%b exp=1", key_err); end
    clr_err = 1; step(); clr_err = 0;
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL badkey_clr2 got=%b exp=0", key_err); end
  endtask

  task automatic test_lock();
    wr_lock = 1; wdata = 32'h1ACC_E551; step(); wr_lock = 0; wdata = 0;
    total++; if (cfg_wr_ok !== 1'b1) begin bad++; $display("FAIL lock_unlock got=%b exp=1", cfg_wr_ok); end
    step();
    total++; if (cfg_wr_ok !== 1'b1) begin bad++; $display("FAIL lock_hold got=%b exp=1", cfg_wr_ok); end
    wr_lock = 1; wdata = 32'h1ACC_E550; step(); wr_lock = 0; wdata = 0;
    total++; if (cfg_wr_ok !== 1'b0) begin bad++; $display("FAIL lock_near got=%b exp=0", cfg_wr_ok); end
    wr_lock = 1; wdata = 32'h1ACC_E551; step();
    wdata = 32'h0; step(); wr_lock = 0;
    total++; if (cfg_wr_ok !== 1'b0) begin bad++; $display("FAIL lock_relock got=%b exp=0", cfg_wr_ok); end
    wr_crr = 1; wdata = 32'h1234_5676; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL lock_kick got=%b exp=1", restart); end
    clk_en = 1; step(); clk_en = 0; step();
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL lock_kick_done got=%b exp=0", restart); end
  endtask

  task automatic test_back_to_back();
    ticks_hi = 0;
    wr_crr = 1; wdata = 32'h76; step(); step(); wr_crr = 0; wdata = 0;
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL b2b_no_err got=%b exp=0", key_err); end
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (restart !== 1'b1) begin bad++; $display("FAIL b2b_hold i=%0d got=%b exp=1", i, restart); end
    end
    clk_en = 1; step(); clk_en = 0;
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL b2b_fire got=%b exp=1", restart); end
    step();
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", restart); end
    for (int i = 0; i < 4; i++) begin
      clk_en = 1; step();
      total++; if (restart !== 1'b0) begin bad++; $display("FAIL b2b_single i=%0d got=%b exp=0", i, restart); end
    end
    clk_en = 0;
    total++; if (ticks_hi !== 1) begin bad++; $display("FAIL b2b_ticks got=%0d exp=1", ticks_hi); end
    // kick landing in FIRE is merged: no second pulse
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0;
    clk_en = 1; step(); clk_en = 0;
    wr_crr = 1; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL fire_merge got=%b exp=0", restart); end
    step();
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL fire_merge2 got=%b exp=0", restart); end
  endtask

  task automatic test_wdt_en();
    wdt_en = 0;
    wr_crr = 1; wdata = 32'h76; step(); wdata = 32'h75; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL dis_restart got=%b exp=0", restart); end
    total++; if (key_err !== 1'b0) begin bad++; $display("FAIL dis_key_err got=%b exp=0", key_err); end
    wdt_en = 1;
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL en_fall_pre got=%b exp=1", restart); end
    wdt_en = 0; step(); wdt_en = 1;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL en_fall_drop got=%b exp=0", restart); end
    clk_en = 1; step(); clk_en = 0;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL en_fall_stay got=%b exp=0", restart); end
  endtask

  task automatic test_reset_pend();
    wr_lock = 1; wdata = 32'h1ACC_E551; step(); wr_lock = 0;
    wr_crr = 1; wdata = 32'h11; step();
    wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1 || key_err !== 1'b1 || cfg_wr_ok !== 1'b1) begin
      bad++; $display("FAIL pend_setup got=%b%b%b exp=111", restart, key_err, cfg_wr_ok); end
    preset = 1; step(); preset = 0;
    total++; if ({restart, cfg_wr_ok, key_err, early_err} !== 4'b0000) begin
      bad++; $display("FAIL pend_reset got=%b exp=0000", {restart, cfg_wr_ok, key_err, early_err}); end
    clk_en = 1; step(); clk_en = 0;
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL pend_dropped got=%b exp=0", restart); end
  endtask

`ifdef WDT_WINDOW_EN
  task automatic test_window();
    win_val = 100; cnt = 150;
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (early_err !== 1'b1) begin bad++; $display("FAIL win_early got=%b exp=1", early_err); end
    total++; if (restart !== 1'b0) begin bad++; $display("FAIL win_early_rst got=%b exp=0", restart); end
    cnt = 80;
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1) begin bad++; $display("FAIL win_open got=%b exp=1", restart); end
    total++; if (early_err !== 1'b1) begin bad++; $display("FAIL win_keep got=%b exp=1", early_err); end
    clk_en = 1; step(); clk_en = 0; step();
    clr_err = 1; step(); clr_err = 0;
    total++; if (early_err !== 1'b0) begin bad++; $display("FAIL win_clr got=%b exp=0", early_err); end
    cnt = 100;
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1 || early_err !== 1'b0) begin
      bad++; $display("FAIL win_edge got=%b%b exp=10", restart, early_err); end
    clk_en = 1; step(); clk_en = 0; step();
    win_val = '1; cnt = 32'hFFFF_FFFF;
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1 || early_err !== 1'b0) begin
      bad++; $display("FAIL win_allones got=%b%b exp=10", restart, early_err); end
    clk_en = 1; step(); clk_en = 0; step();
  endtask
`else
  task automatic test_no_window();
    win_val = 100; cnt = 150;
    wr_crr = 1; wdata = 32'h76; step(); wr_crr = 0; wdata = 0;
    total++; if (restart !== 1'b1 || early_err !== 1'b0) begin
      bad++; $display("FAIL nowin_accept got=%b%b exp=10", restart, early_err); end
    clk_en = 1; step(); clk_en = 0; step();
    win_val = '1; cnt = 0;
  endtask
`endif

  initial begin
    preset = 1; wdt_en = 0; cnt = 0; win_val = '1; ticks_hi = 0;
    idle_inputs();
    test_reset();
    test_kick();
    test_bad_key();
    test_lock();
    test_back_to_back();
    test_wdt_en();
    test_reset_pend();
`ifdef WDT_WINDOW_EN
    test_window();
`else
    test_no_window();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
